// File: rtl/led_mux_if.sv
// ----------------------------------------------------------------------------
// led_mux_if
// Front-panel bundle for led_mux: the ten raw slide switches and the ten
// LEDs.
//   sw  [9:0]  raw switches, asynchronous to any clock
//              (lane0=sw[1:0], lane1=sw[3:2], lane2=sw[5:4], lane3=sw[7:6],
//               select=sw[9:8])
//   led [9:0]  LED vector driven by the mux
// Modports:
//   master  drives sw, observes led (board / testbench side)
//   slave   observes sw, drives led (led_mux side)
// There is no valid/ready handshake: sw is sampled on every clock and led is
// updated on every clock, so both directions are plain level signals.
// ----------------------------------------------------------------------------
interface led_mux_if;
    logic [9:0] sw;
    logic [9:0] led;

    modport master (output sw, input led);
    modport slave (input sw, output led);
endinterface

// File: rtl/led_mux.sv
// ----------------------------------------------------------------------------
// led_mux
// Switch-driven 4:1 multiplexer for the switch/LED front panel. Four 2-bit
// data lanes and a 2-bit select come from the switches; the LEDs show the
// selected lane plus status.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   bus       led_mux_if.slave (sw in, led out)
//
// LED map:
//   led[1:0]  lane[sel]
//   led[5:2]  one-hot of sel (sel 0 -> 0001, sel 3 -> 1000)
//   led[7:6]  2-bit count of select changes, wraps 3 -> 0
//   led[8]    XOR of the two bits of lane[sel]
//   led[9]    one-cycle pulse when sel differs from the previous sel
//
// Parameters:
//   SYNC_STAGES  synchronizer depth, legal 2..4 (default 2)
//   RESET_LED    led value while rst is high and until the first edge after
//                release (default 0)
//
// Optional build macro LED_MUX_COMB_OUT_EN: when defined, the synchronizer
// and output register are bypassed; led[5:0] and led[8] follow raw sw
// combinationally, while led[7:6] and led[9] remain clocked from raw sw[9:8].
// Default build (macro undefined): everything synchronized and registered,
// so a sw change reaches led after SYNC_STAGES+1 rising edges.
// ----------------------------------------------------------------------------
module led_mux #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [9:0]  RESET_LED   = 10'b0
) (
    input  logic      clk,
    input  logic      rst,
    led_mux_if.slave  bus
);

    // Switch word the decode works from: synchronized in the default build,
    // raw in the combinational-output build.
    logic [9:0] src;
    logic [1:0] sel;
    logic [1:0] lane;
    logic [3:0] sel_oh;
    logic       sel_chg;
    logic [1:0] prev_sel;
    logic [1:0] chg_cnt;
    logic [1:0] cnt_next;

    assign sel = src[9:8];

    always_comb begin
        lane = src[1:0];
        unique case (sel)
            2'd0: lane = src[1:0];
            2'd1: lane = src[3:2];
            2'd2: lane = src[5:4];
            2'd3: lane = src[7:6];
        endcase
    end

    assign sel_oh   = 4'b0001 << sel;
    // prev_sel clears on reset, so a nonzero sel right after release counts
    // as one change.
    assign sel_chg  = (sel != prev_sel);
    assign cnt_next = chg_cnt + {1'b0, sel_chg};

`ifndef LED_MUX_COMB_OUT_EN

    logic [SYNC_STAGES-1:0][9:0] sync_q;
    logic [9:0]                  led_q;

    assign src = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            prev_sel <= '0;
            chg_cnt  <= '0;
            led_q    <= RESET_LED;
        end else begin
            sync_q[0] <= bus.sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_sel <= sel;
            chg_cnt  <= cnt_next;
            // The counter field shows the post-increment value so it agrees
            // with the pulse raised in the same cycle.
            led_q    <= {sel_chg, lane[1] ^ lane[0], cnt_next, sel_oh, lane};
        end
    end

    assign bus.led = led_q;

`else

    logic pulse_q;

    assign src = bus.sw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sel <= '0;
            chg_cnt  <= '0;
            pulse_q  <= 1'b0;
        end else begin
            prev_sel <= sel;
            chg_cnt  <= cnt_next;
            pulse_q  <= sel_chg;
        end
    end

    // Combinational bits would otherwise follow sw during reset; hold the
    // whole vector at RESET_LED instead.
    assign bus.led = rst ? RESET_LED
                         : {pulse_q, lane[1] ^ lane[0], chg_cnt, sel_oh, lane};

`endif

endmodule

// File: tb/tb_led_mux.sv
// ----------------------------------------------------------------------------
// tb_led_mux
// Bench for led_mux (default build). A behavioural model turns each sampled
// switch word into the LED word it must produce and queues it; the queue
// depth models the synchronizer delay. A negedge compare process checks the
// DUT against the model every cycle, and directed steps pin literal values.
// ----------------------------------------------------------------------------
module tb_led_mux;

    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [9:0]  RESET_LED   = 10'b0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_mux_if bus ();

    led_mux #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LED   (RESET_LED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- bookkeeping ----------------
    int passed = 0;
    int total  = 0;
    int pulse_seen = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    logic [9:0] exp_q[$];
    logic [9:0] cur_exp;
    logic [1:0] m_prev;
    int         m_changes;

    // LED word for one switch word as seen after synchronization, given the
    // running history of selects.
    task automatic model_led(input logic [9:0] s, output logic [9:0] led_w);
        logic [1:0] sel_v;
        logic [1:0] ln;
        logic [3:0] oh;
        logic       pulse;
        sel_v = s[9:8];
        ln    = s[2*sel_v +: 2];
        oh    = 4'b0001 << sel_v;
        pulse = (sel_v != m_prev);
        if (pulse) m_changes++;
        m_prev = sel_v;
        led_w = {pulse, ln[1] ^ ln[0], 2'(m_changes % 4), oh, ln};
    endtask

    always @(posedge clk or posedge rst) begin
        logic [9:0] w;
        if (rst) begin
            m_prev    = 2'd0;
            m_changes = 0;
            exp_q.delete();
            // Synchronizer flops clear to zero, so the first edges after
            // release see an all-zero switch word.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                model_led(10'd0, w);
                exp_q.push_back(w);
            end
            cur_exp = RESET_LED;
        end else begin
            model_led(bus.sw, w);
            exp_q.push_back(w);
            cur_exp = exp_q.pop_front();
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("led_vs_model", bus.led, cur_exp);
            if (bus.led[9]) pulse_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_sw(input logic [9:0] v);
        @(posedge clk);
        #2 bus.sw = v;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int p0;
        logic [9:0] v;
        logic [1:0] par_tbl [4];
        logic [3:0] oh_tbl  [4];
        logic [1:0] cnt_tbl [4];
        logic [1:0] sel_tbl [4];
        par_tbl = '{2'd0, 2'd1, 2'd1, 2'd0};
        sel_tbl = '{2'd2, 2'd3, 2'd0, 2'd0};
        oh_tbl  = '{4'b0100, 4'b1000, 4'b0001, 4'b0001};
        cnt_tbl = '{2'd2, 2'd3, 2'd0, 2'd0};

        // Test 1: reset with all switches up, then release with sw=0.
        bus.sw = 10'h3FF;
        #1 rst = 1'b1;
        #1 check_en = 1'b1;
        wait_clks(3);
        check("t1_reset_led", bus.led, 10'h000);
        @(posedge clk);
        #2 rst = 1'b0;
        bus.sw = 10'h000;
        wait_clks(3);
        check("t1_after_release", bus.led, 10'b0000000100);
        check("t1_model_pin", cur_exp, 10'b0000000100);

        // Test 2: sel 0, lane0 = 00, other lanes busy.
        set_sw(10'b0011100100);
        wait_clks(3);
        check("t2_sel0", bus.led, 10'b0000000100);

        // Test 3: sel 1, lane1 = 01 -> pulse for one cycle.
        set_sw(10'b0111100110);
        p0 = pulse_seen;
        wait_clks(3);
        check("t3_pulse_cycle", bus.led, 10'b1101001001);
        check("t3_model_pin", cur_exp, 10'b1101001001);
        @(negedge clk);
        check("t3_after_pulse", bus.led, 10'b0101001001);

        // Test 4: sel 1 -> 2 -> 3 -> 0, five clocks each.
        for (int k = 0; k < 3; k++) begin
            set_sw({sel_tbl[k], 8'b11100110});
            p0 = pulse_seen;
            wait_clks(3);
            check($sformatf("t4_count_sel%0d", sel_tbl[k]), {8'd0, bus.led[7:6]}, {8'd0, cnt_tbl[k]});
            check($sformatf("t4_onehot_sel%0d", sel_tbl[k]), {6'd0, bus.led[5:2]}, {6'd0, oh_tbl[k]});
            wait_clks(1);
            #1 check($sformatf("t4_pulses_sel%0d", sel_tbl[k]), 10'(pulse_seen - p0), 10'd1);
        end

        // Test 5: sel 3 fixed, walk lane3 through 00..11.
        set_sw({2'b11, 2'b00, 6'b100110});
        wait_clks(5);
        for (int k = 0; k < 4; k++) begin
            v = {2'b11, 2'(k), 6'b100110};
            set_sw(v);
            p0 = pulse_seen;
            wait_clks(4);
            check($sformatf("t5_lane_%0d", k), {8'd0, bus.led[1:0]}, {8'd0, 2'(k)});
            check($sformatf("t5_parity_%0d", k), {9'd0, bus.led[8]}, {8'd0, par_tbl[k]});
            #1 check($sformatf("t5_no_pulse_%0d", k), 10'(pulse_seen - p0), 10'd0);
        end

        // Test 6: asynchronous reset between edges while led is nonzero.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("t6_async_clear", bus.led, 10'h000);
        bus.sw = {2'b10, 8'b11100110};
        wait_clks(2);
        @(posedge clk);
        #2 rst = 1'b0;
        p0 = pulse_seen;
        wait_clks(3);
        check("t6_pulse_count1", {8'd0, bus.led[9], bus.led[7:6] == 2'd1}, 10'b11);
        wait_clks(3);
        #1 check("t6_one_pulse", 10'(pulse_seen - p0), 10'd1);

        // Select toggling every cycle: one pulse per cycle, counter 1 + 8.
        p0 = pulse_seen;
        for (int k = 0; k < 8; k++) begin
            set_sw({(k % 2 == 0) ? 2'd1 : 2'd2, 8'b11100110});
        end
        wait_clks(6);
        #1 check("toggle_pulses", 10'(pulse_seen - p0), 10'd8);
        check("toggle_count", {8'd0, bus.led[7:6]}, 10'd1);

        // Randomized phase, model-checked every cycle.
        for (int c = 0; c < 400; c++) begin
            int r;
            @(posedge clk);
            #2;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                bus.sw = 10'($urandom);
            end else if (r < 6) begin
                bus.sw[9:8] = 2'($urandom_range(0, 3));
            end else if (r == 6) begin
                bus.sw[7:0] = 8'($urandom);
            end
            if ($urandom_range(0, 59) == 0) begin
                #1 rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #2 rst = 1'b0;
            end
        end
        wait_clks(4);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
